rom_dl_sequencer: RTL
=====================

ROM_DL_SEQUENCER -- requirements
Module: rom_dl_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- P2_BASE, 25'h30000: first address routed to the sprite/gfx SDRAM port.
- SND_LO / SND_HI, 25'h20000 / 25'h2FFFF: sound-ROM window, inclusive.
- PROM_BASE, 25'hA0000: colour/height PROM window base.
- ACK_TIMEOUT, 8'd255: cycles allowed for SDRAM acknowledge.
- HOLD_CYCLES, 16'hFFFF: core reset stretch after load.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk_sys, in, 1: single clock.
- reset, in, 1: reset, asynchronous, active-high.
- ioctl_download / ioctl_wr, in, 1 / 1: HPS download active / byte strobe.
- ioctl_index, in, 8: 0 = ROM, 1 = core_mod.
- ioctl_addr / ioctl_dout, in, 25 / 8: byte address / data.
- ioctl_wait, out, 1: stall HPS.
- port1_req / port2_req, out, 1: toggle requests.
- port1_ack / port2_ack, in, 1: toggle acks.
- port1_a / port2_a, out, 23: word addresses.
- port_ds, out, 2: byte selects.
- port_d, out, 16: duplicated data.
- port_we, out, 1: write enable.
- snd_wr, out, 1: sound dpram write strobe; snd_addr, out, 16.
- prom_wr, out, 1: PROM write strobe; prom_addr, out, 12.
- wr_data, out, 8: latched byte.
- core_mod, out, 8: variant select.
- rom_loaded, out, 1: load complete.
- core_reset, out, 1: reset to target_top.
- dl_error, out, 1: sticky ack timeout.

Function
REQ-003 SHALL capture ioctl_addr and ioctl_dout only on a 0->1 edge of ioctl_wr, once per strobe.
REQ-004 With index 1, SHALL load core_mod from dout on that edge, issue no SDRAM request, and leave rom_loaded unaffected.
REQ-005 FSM states SHALL be IDLE, ISSUE, WAIT_ACK. IDLE->ISSUE on a captured index-0 byte; ISSUE->WAIT_ACK after one cycle; WAIT_ACK->IDLE when every issued req equals its ack, or on timeout.
REQ-006 In ISSUE:
- toggle port1_req for every byte;
- toggle port2_req also when addr >= P2_BASE;
- port1_a = addr[23:1];
- port2_a = (addr - P2_BASE)[23:1];
- port_ds = {addr[0], ~addr[0]};
- port_d = {dout, dout}.
REQ-007 port_we SHALL be high while index-0 download is active.
REQ-008 snd_wr SHALL pulse for exactly one cycle in ISSUE when SND_LO <= addr <= SND_HI, with snd_addr = addr[15:0].
REQ-009 prom_wr SHALL pulse for one cycle in ISSUE when PROM_BASE <= addr < PROM_BASE+12'hFFF, with prom_addr = addr - PROM_BASE.
REQ-010 ioctl_wait SHALL be high from the capture cycle until WAIT_ACK exits.
REQ-011 A new ioctl_wr edge arriving while not IDLE SHALL be held in a single pending slot and serviced next. A second overrun SHALL set dl_error and drop the byte.
REQ-012 The WAIT_ACK counter SHALL start at 0. At ACK_TIMEOUT it SHALL set dl_error, return to IDLE, and resynchronise the req/ack parity.
REQ-013 rom_loaded SHALL set on the 1->0 edge of an index-0 download and SHALL clear when an index-0 download starts.
REQ-014 core_reset SHALL be high while !rom_loaded or a download is active. After that, it SHALL stay high for HOLD_CYCLES more cycles, then fall.
REQ-015 Address arithmetic SHALL be 25-bit unsigned; an address below P2_BASE SHALL never toggle port2_req.

Reset
REQ-016 On reset the block SHALL clear:
- state = IDLE;
- port1_req = port2_req = 0;
- strobes = 0;
- ioctl_wait = 0;
- core_mod = 0;
- rom_loaded = 0;
- dl_error = 0;
- pending slot empty;
- core_reset = 1;
- hold counter = HOLD_CYCLES.
REQ-017 Reset mid-transfer SHALL abandon the byte without a further toggle. The SDRAM side is expected to resync via equal req/ack after its own reset.

Structure
REQ-018 Address-window constants and the FSM state enum SHALL live in a shared package, m62_dl_pkg.
REQ-019 One sub-module, dl_reset_stretch, SHALL implement the REQ-014 counter.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Byte 0x5A at addr 0x00001 → port1_req toggles once, port1_a=0, ds=2'b10, port_d=16'h5A5A, port2_req steady, no snd_wr.
- Byte at 0x30004 → both reqs toggle, port2_a=2; ioctl_wait stays high until both acks match.
- Byte at 0x20010 → snd_wr one cycle with snd_addr=16'h0010; byte at 0xA0300 → prom_wr with prom_addr=12'h300.
- Acks withheld → dl_error=1 after ACK_TIMEOUT cycles; FSM back in IDLE.
- Index 1 byte 0x0B → core_mod=8'h0B; no SDRAM toggle.
- Download end → rom_loaded=1; core_reset falls exactly HOLD_CYCLES later. An async reset pulse mid-WAIT_ACK → all outputs at reset values.

Source files
------------

// File: rtl/m62_dl_pkg.sv
// Shared address-window defaults, download indices and sequencer state encoding
// for the M62 ROM download path.
package m62_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } dl_state_e;

  localparam logic [24:0] DEF_P2_BASE   = 25'h0030000;
  localparam logic [24:0] DEF_SND_LO    = 25'h0020000;
  localparam logic [24:0] DEF_SND_HI    = 25'h002FFFF;
  localparam logic [24:0] DEF_PROM_BASE = 25'h00A0000;
  localparam logic [24:0] PROM_SPAN     = 25'h0000FFF;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;

  function automatic logic in_window(input logic [24:0] addr,
                                     input logic [24:0] lo,
                                     input logic [24:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/dl_reset_stretch.sv
// Holds core_reset while the hold request is active, then for HOLD_CYCLES more
// cycles before releasing it.
module dl_reset_stretch #(
  parameter logic [15:0] HOLD_CYCLES = 16'hFFFF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic hold_req,
  output logic core_reset
);

  logic [15:0] cnt_r;
  logic        core_reset_r;

  // Reload on hold, count down afterwards; output drops once the last hold cycle is spent
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_r        <= HOLD_CYCLES;
      core_reset_r <= 1'b1;
    end else if (hold_req) begin
      cnt_r        <= HOLD_CYCLES;
      core_reset_r <= 1'b1;
    end else begin
      if (cnt_r != 16'd0) begin
        cnt_r <= cnt_r - 16'd1;
      end else begin
        cnt_r <= 16'd0;
      end
      core_reset_r <= (cnt_r > 16'd1);
    end
  end

  assign core_reset = core_reset_r;

endmodule

// File: rtl/rom_dl_sequencer.sv
// Turns HPS ioctl byte strobes into toggle-handshake SDRAM writes plus sound
// and PROM dpram strobes, and sequences the core reset around the ROM load.
module rom_dl_sequencer
  import m62_dl_pkg::*;
#(
  parameter logic [24:0] P2_BASE     = DEF_P2_BASE,
  parameter logic [24:0] SND_LO      = DEF_SND_LO,
  parameter logic [24:0] SND_HI      = DEF_SND_HI,
  parameter logic [24:0] PROM_BASE   = DEF_PROM_BASE,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255,
  parameter logic [15:0] HOLD_CYCLES = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  output logic        port2_req,
  input  logic        port1_ack,
  input  logic        port2_ack,
  output logic [22:0] port1_a,
  output logic [22:0] port2_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        port_we,
  output logic        snd_wr,
  output logic [15:0] snd_addr,
  output logic        prom_wr,
  output logic [11:0] prom_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  core_mod,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        dl_error
);

  dl_state_e   state_r, state_nx_s;
  logic        wr_d_r, dl_d_r;
  logic        pend_vld_r;
  logic [24:0] pend_addr_r;
  logic [7:0]  pend_data_r;
  logic [7:0]  cnt_r;
  logic        ioctl_wait_r, port_we_r, snd_wr_r, prom_wr_r;
  logic        port1_req_r, port2_req_r;
  logic [22:0] port1_a_r, port2_a_r;
  logic [1:0]  port_ds_r;
  logic [15:0] port_d_r, snd_addr_r;
  logic [11:0] prom_addr_r;
  logic [7:0]  wr_data_r, core_mod_r;
  logic        rom_loaded_r, dl_error_r;

  logic        edge_s, cap0_s, cap1_s, busy_cap_s, acks_match_s;
  logic        issue_s, use_pend_s, pend_load_s, pend_clr_s, pend_nx_s;
  logic        overrun_s, timeout_s, hold_req_s;
  logic [24:0] sel_addr_s;
  logic [7:0]  sel_data_s;
  logic        p2_hit_s, snd_hit_s, prom_hit_s;

  assign edge_s       = ioctl_wr & ~wr_d_r;
  assign cap0_s       = edge_s & (ioctl_index == IDX_ROM);
  assign cap1_s       = edge_s & (ioctl_index == IDX_MOD);
  assign busy_cap_s   = cap0_s & (state_r != ST_IDLE);
  assign acks_match_s = (port1_req_r == port1_ack) & (port2_req_r == port2_ack);
  assign pend_nx_s    = pend_load_s | (pend_vld_r & ~pend_clr_s);

  // A queued byte always goes out before a freshly strobed one
  assign sel_addr_s = use_pend_s ? pend_addr_r : ioctl_addr;
  assign sel_data_s = use_pend_s ? pend_data_r : ioctl_dout;
  assign p2_hit_s   = (sel_addr_s >= P2_BASE);
  assign snd_hit_s  = in_window(sel_addr_s, SND_LO, SND_HI);
  assign prom_hit_s = in_window(sel_addr_s, PROM_BASE, PROM_BASE + PROM_SPAN - 25'd1);

  // FSM state register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, issue decision and pending-slot control
  always_comb begin
    state_nx_s  = state_r;
    issue_s     = 1'b0;
    use_pend_s  = 1'b0;
    pend_load_s = 1'b0;
    pend_clr_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_vld_r) begin
          issue_s     = 1'b1;
          use_pend_s  = 1'b1;
          state_nx_s  = ST_ISSUE;
          pend_load_s = cap0_s;
          pend_clr_s  = ~cap0_s;
        end else if (cap0_s) begin
          issue_s    = 1'b1;
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nx_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (acks_match_s) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == ACK_TIMEOUT) begin
          timeout_s  = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    pend_load_s = pend_load_s | (busy_cap_s & ~pend_vld_r);
    overrun_s   = busy_cap_s & pend_vld_r;
  end

  // SDRAM request toggles and per-byte address/data registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      port1_req_r <= 1'b0;
      port2_req_r <= 1'b0;
      port1_a_r   <= 23'd0;
      port2_a_r   <= 23'd0;
      port_ds_r   <= 2'b00;
      port_d_r    <= 16'd0;
      snd_addr_r  <= 16'd0;
      prom_addr_r <= 12'd0;
      wr_data_r   <= 8'd0;
      snd_wr_r    <= 1'b0;
      prom_wr_r   <= 1'b0;
    end else begin
      snd_wr_r  <= issue_s & snd_hit_s;
      prom_wr_r <= issue_s & prom_hit_s;
      if (issue_s) begin
        port1_req_r <= ~port1_req_r;
        port2_req_r <= p2_hit_s ? ~port2_req_r : port2_req_r;
        port1_a_r   <= sel_addr_s[23:1];
        port2_a_r   <= 23'((sel_addr_s - P2_BASE) >> 1);
        port_ds_r   <= {sel_addr_s[0], ~sel_addr_s[0]};
        port_d_r    <= {sel_data_s, sel_data_s};
        snd_addr_r  <= sel_addr_s[15:0];
        prom_addr_r <= 12'(sel_addr_s - PROM_BASE);
        wr_data_r   <= sel_data_s;
      end else if (timeout_s) begin
        // Give up on the outstanding write and adopt the SDRAM's parity
        port1_req_r <= port1_ack;
        port2_req_r <= port2_ack;
      end
    end
  end

  // Strobe edge detect, pending slot, ack counter and download status
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_d_r       <= 1'b0;
      dl_d_r       <= 1'b0;
      pend_vld_r   <= 1'b0;
      pend_addr_r  <= 25'd0;
      pend_data_r  <= 8'd0;
      cnt_r        <= 8'd0;
      ioctl_wait_r <= 1'b0;
      port_we_r    <= 1'b0;
      core_mod_r   <= 8'd0;
      rom_loaded_r <= 1'b0;
      dl_error_r   <= 1'b0;
    end else begin
      wr_d_r       <= ioctl_wr;
      dl_d_r       <= ioctl_download;
      pend_vld_r   <= pend_nx_s;
      cnt_r        <= (state_r == ST_WAIT_ACK) ? cnt_r + 8'd1 : 8'd0;
      ioctl_wait_r <= (state_nx_s != ST_IDLE) | pend_nx_s;
      port_we_r    <= ioctl_download & (ioctl_index == IDX_ROM);
      if (pend_load_s) begin
        pend_addr_r <= ioctl_addr;
        pend_data_r <= ioctl_dout;
      end
      if (cap1_s) begin
        core_mod_r <= ioctl_dout;
      end
      if (overrun_s | timeout_s) begin
        dl_error_r <= 1'b1;
      end
      if (ioctl_index == IDX_ROM) begin
        if (ioctl_download & ~dl_d_r) begin
          rom_loaded_r <= 1'b0;
        end else if (~ioctl_download & dl_d_r) begin
          rom_loaded_r <= 1'b1;
        end
      end
    end
  end

  assign hold_req_s = ~rom_loaded_r | ioctl_download;

  dl_reset_stretch #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_reset_stretch (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .hold_req   (hold_req_s),
    .core_reset (core_reset)
  );

  assign ioctl_wait = ioctl_wait_r;
  assign port1_req  = port1_req_r;
  assign port2_req  = port2_req_r;
  assign port1_a    = port1_a_r;
  assign port2_a    = port2_a_r;
  assign port_ds    = port_ds_r;
  assign port_d     = port_d_r;
  assign port_we    = port_we_r;
  assign snd_wr     = snd_wr_r;
  assign snd_addr   = snd_addr_r;
  assign prom_wr    = prom_wr_r;
  assign prom_addr  = prom_addr_r;
  assign wr_data    = wr_data_r;
  assign core_mod   = core_mod_r;
  assign rom_loaded = rom_loaded_r;
  assign dl_error   = dl_error_r;

endmodule
